// File: rtl/store_buffer_pkg.sv
// store_buffer_pkg: shared entry layout, drain FSM states and word-compare boundary for store_buffer.
package store_buffer_pkg;
    localparam int SB_AW = 32;
    localparam int SB_DW = 32;
    localparam int SB_WORD_LSB = 2;
    typedef struct packed {
        logic [SB_AW-1:0] addr;
        logic [SB_DW-1:0] data;
    } sb_entry_t;
    typedef enum logic {SB_IDLE, SB_REQ} sb_state_e;
endpackage

// File: rtl/sb_fwd_match.sv
// sb_fwd_match: load-to-store forwarding, youngest matching valid entry wins.
module sb_fwd_match
    import store_buffer_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW = SB_AW,
    parameter int DW = SB_DW
) (
    input  sb_entry_t                    entries_i [DEPTH],
    input  logic [DEPTH-1:0]             valid_i,
    input  logic [$clog2(DEPTH)-1:0]     tail_i,
    input  logic [AW-1:0]                ld_addr_i,
    output logic                         ld_hit_o,
    output logic [DW-1:0]                ld_data_o
);
    localparam int PW = $clog2(DEPTH);
    logic [PW-1:0] idx;
    logic unused_lsb;
    // Walk oldest to youngest so the last match (closest to tail) sticks.
    always_comb begin
        ld_hit_o = 1'b0;
        ld_data_o = '0;
        idx = '0;
        unused_lsb = ^ld_addr_i[SB_WORD_LSB-1:0];
        for (int k = DEPTH - 1; k >= 0; k--) begin
            idx = tail_i - PW'(k + 1);
            unused_lsb = unused_lsb ^ (^entries_i[idx].addr[SB_WORD_LSB-1:0]);
            if (valid_i[idx] && entries_i[idx].addr[AW-1:SB_WORD_LSB] == ld_addr_i[AW-1:SB_WORD_LSB]) begin
                ld_hit_o = 1'b1;
                ld_data_o = entries_i[idx].data;
            end
        end
    end
endmodule

// File: rtl/store_buffer.sv
// store_buffer: posted-write FIFO between core and slow memory with load forwarding.
// Define STORE_BUFFER_MERGE_EN to coalesce a store into the youngest entry on a word-address match.
module store_buffer
    import store_buffer_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW = SB_AW,
    parameter int DW = SB_DW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          st_valid,
    input  logic [AW-1:0] st_addr,
    input  logic [DW-1:0] st_data,
    output logic          full,
    output logic          empty,
    output logic          overflow,
    input  logic [AW-1:0] ld_addr,
    output logic          ld_hit,
    output logic [DW-1:0] ld_data,
    output logic          mem_req,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic          mem_ack
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    sb_entry_t        entries_q [DEPTH];
    sb_state_e        state_q;
    logic [PW-1:0]    head_q, tail_q;
    logic [CW-1:0]    count_q, count_d;
    logic             full_q, empty_q, overflow_q, mem_req_q;
    logic [DEPTH-1:0] valid;
    logic             merge, push, pop;

    always_comb begin
        for (int i = 0; i < DEPTH; i++) valid[i] = {1'b0, PW'(i) - head_q} < count_q;
    end

`ifdef STORE_BUFFER_MERGE_EN
    logic [PW-1:0] young;
    assign young = tail_q - PW'(1);
    // The youngest entry is the head only when count is 1; never touch it while it is being drained.
    assign merge = st_valid && count_q != '0 && !(state_q == SB_REQ && count_q == CW'(1)) &&
                   entries_q[young].addr[AW-1:SB_WORD_LSB] == st_addr[AW-1:SB_WORD_LSB];
`else
    assign merge = 1'b0;
`endif

    assign push = st_valid && !merge && !full_q;
    assign pop = state_q == SB_REQ && mem_ack;
    assign count_d = count_q + CW'(push) - CW'(pop);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) entries_q[i] <= '0;
            state_q <= SB_IDLE;
            head_q <= '0;
            tail_q <= '0;
            count_q <= '0;
            full_q <= 1'b0;
            empty_q <= 1'b1;
            overflow_q <= 1'b0;
            mem_req_q <= 1'b0;
        end else begin
            if (push) entries_q[tail_q] <= '{addr: st_addr, data: st_data};
`ifdef STORE_BUFFER_MERGE_EN
            if (merge) entries_q[young].data <= st_data;
`endif
            if (push) tail_q <= tail_q + PW'(1);
            if (pop) head_q <= head_q + PW'(1);
            count_q <= count_d;
            full_q <= count_d == CW'(DEPTH);
            empty_q <= count_d == '0;
            if (st_valid && !merge && full_q) overflow_q <= 1'b1;
            if (state_q == SB_IDLE) begin
                if (count_q != '0) begin
                    state_q <= SB_REQ;
                    mem_req_q <= 1'b1;
                end
            end else if (mem_ack) begin
                state_q <= SB_IDLE;
                mem_req_q <= 1'b0;
            end
        end
    end

    sb_fwd_match #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) u_fwd (
        .entries_i (entries_q),
        .valid_i   (valid),
        .tail_i    (tail_q),
        .ld_addr_i (ld_addr),
        .ld_hit_o  (ld_hit),
        .ld_data_o (ld_data)
    );

    assign full = full_q;
    assign empty = empty_q;
    assign overflow = overflow_q;
    assign mem_req = mem_req_q;
    assign mem_addr = entries_q[head_q].addr;
    assign mem_wdata = entries_q[head_q].data;
endmodule

// File: doc/store_buffer.md
# store_buffer

Posted-write buffer between the single-cycle core's data port (MemWrite/DataAdr/WriteData) and a slower multi-cycle data memory. It accepts one store per cycle from the core, queues it in a small circular FIFO, and drains entries to memory over a req/ack handshake. Loads are checked against queued stores and forwarded from the youngest matching entry, so the core always reads its own writes.

## Interface
- DEPTH, 4, number of entries; must be a power of 2, at least 2
- AW, 32, address width
- DW, 32, data width
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- st_valid  in  1  core store request (MemWrite)
- st_addr  in  AW  store byte address (DataAdr)
- st_data  in  DW  store data (WriteData)
- full  out  1  count == DEPTH (registered)
- empty  out  1  count == 0 (registered)
- overflow  out  1  sticky; a store was dropped
- ld_addr  in  AW  core load address
- ld_hit  out  1  ld_addr matches a valid entry
- ld_data  out  DW  data of the youngest matching entry; 0 when no hit
- mem_req  out  1  drain request (registered)
- mem_addr  out  AW  address of the head entry
- mem_wdata  out  DW  data of the head entry
- mem_ack  in  1  memory accepted the head entry

## Operation
- Storage: DEPTH entries {addr, data}. Head/tail pointers are log2(DEPTH) bits wide and wrap modulo DEPTH. Count is log2(DEPTH)+1 bits wide.
- Push: st_valid && !full at the clock edge writes the entry at tail, then tail+1.
- If st_valid && full, the store is dropped and overflow is set until reset. This holds even when a pop occurs on the same edge, because full is the registered value.
- Drain FSM, IDLE:
  - Go to REQ when count > 0.
  - mem_req is 0 in IDLE.
- Drain FSM, REQ:
  - mem_req = 1, and mem_addr/mem_wdata show the head entry, held stable.
  - On the edge where mem_ack = 1: pop the head (head+1, count-1) and return to IDLE.
  - mem_ack is ignored in IDLE.
- Simultaneous push and pop: count is unchanged, and both pointers advance.
- Address compare uses only addr[AW-1:2]; all accesses are word-sized.
- Forwarding: combinational match of ld_addr against every valid entry, including the head while it is in REQ. When several entries match, the youngest (closest to tail) wins.
- The store being pushed in the current cycle is not visible to forwarding.
- Reset mid-drain: mem_req drops immediately (asynchronous) and all entries are discarded. The memory must tolerate an abandoned request.

## Timing
- Values after reset:
  - full = 0, empty = 1, overflow = 0
  - ld_hit = 0, ld_data = 0
  - mem_req = 0, mem_addr = 0, mem_wdata = 0
  - FSM in IDLE, head = tail = count = 0
- A push at edge E0 has these effects:
  - The entry is visible to forwarding after E0.
  - empty falls after E0.
  - mem_req rises after E1 (if the buffer was previously idle).
- Earliest ack is at E2. Pop happens at the ack edge, and mem_req falls after that edge.
- Drain throughput is at most one entry per 2 cycles. Fill rate is one per cycle.
- full and empty update on the edge after the push or pop that causes them.

## Configuration
- STORE_BUFFER_MERGE_EN defined: a store whose word address equals the youngest valid entry's address overwrites that entry's data, with no allocation.
  - Merge is allowed even when full, so the store is not dropped.
  - Merge is suppressed if that entry is the head and the FSM is in REQ; the store then allocates normally (or is dropped if full).
- Not defined: every accepted store allocates a new entry.

## Structure
- store_buffer_pkg holds:
  - the typedef sb_entry_t {addr, data}
  - the enum sb_state_e {SB_IDLE, SB_REQ}
  - the constant SB_WORD_LSB = 2
- Sub-module sb_fwd_match: takes the entry array, per-entry valid bits, tail and ld_addr, and returns ld_hit/ld_data with youngest-first priority.

## Test plan
- Reset, then a single store 0x40 <- 0xDEADBEEF: ld_addr = 0x40 gives ld_hit = 1 and 0xDEADBEEF the next cycle. mem_req rises 2 cycles after the push. Ack at the earliest edge gives empty = 1 and ld_hit = 0.
- Fill with mem_ack = 0, DEPTH = 4, stores to 0x0/0x4/0x8/0xC: full = 1. A 5th store sets overflow = 1 and count stays 4. Memory then receives the 4 writes in order.
- Two stores to 0x20 (0x1 then 0x2) with other traffic in between, merge off: ld_data = 0x2 and two memory writes occur.
- Push and ack on the same edge at count = 2: count stays 2, and both head and tail advance.
- Assert reset while mem_req = 1 with 3 entries queued: mem_req = 0 immediately, empty = 1, and no further memory writes occur.
- STORE_BUFFER_MERGE_EN, back-to-back stores 0x30 <- 0xA then 0x30 <- 0xB with the memory stalled: count = 1, forwarding returns 0xB, and exactly one memory write of 0xB occurs.
